// File: rtl/pwm_bank.sv
// Multi-channel PWM bank on the MMIO bus: shared prescaler, programmable period,
// edge/centre alignment, per-channel polarity and boundary-shadowed TOP/DUTY.
module pwm_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                cs,
  input  logic                wren,
  input  logic [4:0]          adr,
  input  logic [31:0]         di,
  output logic [31:0]         dout,  // registered read data ("do" is a reserved word)
  output logic [CHANNELS-1:0] out,
  output logic                irq
);

  localparam logic [4:0] ADR_CTRL   = 5'd0;
  localparam logic [4:0] ADR_PRESC  = 5'd1;
  localparam logic [4:0] ADR_TOP    = 5'd2;
  localparam logic [4:0] ADR_STATUS = 5'd3;

  logic                   en, center, irq_en;
  logic [CHANNELS-1:0]    inv;
  logic [PRESC_WIDTH-1:0] presc, psc;
  logic [WIDTH-1:0]       top, top_s, cnt, cnt_nxt;
  logic [WIDTH-1:0]       duty   [CHANNELS];
  logic [WIDTH-1:0]       duty_s [CHANNELS];
  logic                   down, down_nxt, last, tick, boundary;
  logic                   wrap, wrap_clr, wr, rd;
  logic [31:0]            rdata;
  logic                   unused_di;

  assign wr        = cs & wren;
  assign rd        = cs & ~wren;
  assign tick      = en && (psc == presc);
  assign boundary  = tick & last;
  assign wrap_clr  = wr && (adr == ADR_STATUS) && di[0];
  assign irq       = wrap & irq_en;
  assign unused_di = ^di;

  // Next counter value; "last" marks the final step of a period.
  always_comb begin
    cnt_nxt  = '0;
    down_nxt = 1'b0;
    last     = 1'b0;
    if (!center || top_s == '0) begin
      last    = (cnt >= top_s);
      cnt_nxt = last ? '0 : cnt + 1'b1;
    end else if (down || cnt >= top_s) begin
      last     = (cnt == WIDTH'(1));
      cnt_nxt  = cnt - 1'b1;
      down_nxt = !last;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    case (adr)
      ADR_CTRL:   rdata[CHANNELS+2:0]    = {inv, irq_en, center, en};
      ADR_PRESC:  rdata[PRESC_WIDTH-1:0] = presc;
      ADR_TOP:    rdata[WIDTH-1:0]       = top;
      ADR_STATUS: rdata[0]               = wrap;
      default: begin
        for (int i = 0; i < CHANNELS; i++)
          if (int'(adr) == 4 + i) rdata[WIDTH-1:0] = duty[i];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      en     <= 1'b0;
      center <= 1'b0;
      irq_en <= 1'b0;
      inv    <= '0;
      presc  <= '0;
      top    <= '1;
      top_s  <= '1;
      for (int i = 0; i < CHANNELS; i++) begin
        duty[i]   <= '0;
        duty_s[i] <= '0;
      end
      psc  <= '0;
      cnt  <= '0;
      down <= 1'b0;
      wrap <= 1'b0;
      out  <= '0;
      dout <= '0;
    end else begin
      if (wr) begin
        case (adr)
          ADR_CTRL: begin
            en     <= di[0];
            center <= di[1];
            irq_en <= di[2];
            inv    <= di[CHANNELS+2:3];
          end
          ADR_PRESC:  presc <= di[PRESC_WIDTH-1:0];
          ADR_TOP:    top   <= di[WIDTH-1:0];
          ADR_STATUS: ;
          default: begin
            for (int i = 0; i < CHANNELS; i++)
              if (int'(adr) == 4 + i) duty[i] <= di[WIDTH-1:0];
          end
        endcase
      end

      if (!en) begin
        psc  <= '0;
        cnt  <= '0;
        down <= 1'b0;
      end else if (tick) begin
        psc  <= '0;
        cnt  <= cnt_nxt;
        down <= down_nxt;
      end else begin
        psc <= psc + 1'b1;
      end

      // Shadows track software registers while idle, else only at period boundaries.
      if (!en || boundary) begin
        top_s <= top;
        for (int i = 0; i < CHANNELS; i++) duty_s[i] <= duty[i];
      end

      wrap <= boundary | (wrap & ~wrap_clr);

      for (int i = 0; i < CHANNELS; i++)
        out[i] <= en ? ((cnt < duty_s[i]) ^ inv[i]) : inv[i];

      dout <= rd ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Randomised bench for pwm_bank: an arithmetic period model predicts out, irq
// and read data every cycle; directed runs pin the documented waveforms.
module tb_pwm_bank;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          cs, wren;
  logic [4:0]    adr;
  logic [31:0]   di;
  logic [31:0]   dout;
  logic [CH-1:0] out;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  int m_en, m_center, m_irq_en, m_inv, m_presc, m_top, m_wrap;
  int m_duty   [CH];
  int m_duty_s [CH];
  int hi0, hi1;

  pwm_bank #(.CHANNELS(CH), .WIDTH(8), .PRESC_WIDTH(8)) dut (
    .clk(clk), .n_reset(n_reset), .cs(cs), .wren(wren), .adr(adr),
    .di(di), .dout(dout), .out(out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_write(input int a, input logic [31:0] d);
    case (a)
      0: begin m_en = d[0]; m_center = d[1]; m_irq_en = d[2]; m_inv = int'(d[6:3]); end
      1: m_presc = int'(d[7:0]);
      2: m_top   = int'(d[7:0]);
      default: if (a >= 4 && a < 4 + CH) m_duty[a-4] = int'(d[7:0]);
    endcase
  endfunction

  function automatic int model_read(input int a);
    case (a)
      0: return (m_inv << 3) | (m_irq_en << 2) | (m_center << 1) | m_en;
      1: return m_presc;
      2: return m_top;
      3: return m_wrap;
      default: return (a >= 4 && a < 4 + CH) ? m_duty[a-4] : 0;
    endcase
  endfunction

  // Counter value and boundary flag for cycle c after enable, from period arithmetic.
  function automatic void model_pos(input int c, output int cnt, output bit bnd);
    int j, q;
    bit tk;
    j  = c / (m_presc + 1);
    tk = (c % (m_presc + 1)) == m_presc;
    if (m_top == 0) begin
      cnt = 0; bnd = tk;
    end else if (m_center == 0) begin
      q = j % (m_top + 1); cnt = q; bnd = tk && (q == m_top);
    end else begin
      q = j % (2 * m_top);
      cnt = (q <= m_top) ? q : 2 * m_top - q;
      bnd = tk && (q == 2 * m_top - 1);
    end
  endfunction

  task automatic bus_write(input int a, input logic [31:0] d);
    cs = 1'b1; wren = 1'b1; adr = 5'(a); di = d;
    @(negedge clk);
    cs = 1'b0; wren = 1'b0; di = '0;
    model_write(a, d);
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    cs = 1'b1; wren = 1'b0; adr = 5'(a);
    @(negedge clk);
    cs = 1'b0;
    d = dout;
  endtask

  task automatic run_scenario(input int p, t, center, inv, ien, input logic [CH-1:0][7:0] dv,
                              input int ncyc, input bit rnd, input bit clr_mode,
                              input int wr_cyc, input int wr_val, input int win);
    logic [31:0] exp_out, exp_dout, d;
    int ctrl, cnt, kind, a, ch;
    bit bnd, clr, dw;
    ctrl = (inv << 3) | (ien << 2) | (center << 1);
    bus_write(1, 32'(p));
    bus_write(2, 32'(t));
    for (int i = 0; i < CH; i++) bus_write(4 + i, 32'(dv[i]));
    bus_write(0, 32'(ctrl));
    bus_write(3, 32'd1);
    m_wrap = 0;
    check("idle_out", 32'(out), 32'(inv));
    check("idle_irq", 32'(irq), 32'd0);
    bus_write(0, 32'(ctrl | 1));
    for (int i = 0; i < CH; i++) m_duty_s[i] = m_duty[i];
    exp_out = 32'(inv); exp_dout = '0; hi0 = 0; hi1 = 0;
    for (int c = 0; c < ncyc; c++) begin
      check("out", 32'(out), exp_out);
      check("irq", 32'(irq), 32'(m_wrap & m_irq_en));
      check("dout", dout, exp_dout);
      if (c >= 1 && c <= win) hi0 += int'(out[0]);
      else if (c > win && c <= 2 * win) hi1 += int'(out[0]);
      model_pos(c, cnt, bnd);
      cs = 1'b0; wren = 1'b0; di = '0;
      kind = 0; clr = 1'b0; dw = 1'b0; a = 0; d = '0;
      if (rnd) begin
        kind = $urandom_range(0, 9);
        kind = (kind < 2) ? 1 : (kind == 2) ? 2 : (kind < 5) ? 3 : 0;
        if (bnd && $urandom_range(0, 2) == 0) kind = 2;
      end
      if (clr_mode && (bnd || c % 8 == 3)) kind = 2;
      if (c == wr_cyc) kind = 4;
      exp_out = '0;
      for (int i = 0; i < CH; i++) exp_out[i] = (cnt < m_duty_s[i]) ^ inv[i];
      exp_dout = '0;
      case (kind)
        1: begin ch = $urandom_range(0, CH - 1); a = 4 + ch; d = 32'($urandom_range(0, t + 2)); dw = 1'b1; end
        2: begin a = 3; d = rnd ? $urandom : 32'd1; clr = d[0]; dw = 1'b1; end
        3: begin a = $urandom_range(0, 31); exp_dout = 32'(model_read(a)); end
        4: begin a = 4; d = 32'(wr_val); dw = 1'b1; end
        default: ;
      endcase
      if (kind != 0) begin cs = 1'b1; wren = dw; adr = 5'(a); di = d; end
      m_wrap = int'(bnd | (m_wrap != 0 && !clr));
      if (bnd) for (int i = 0; i < CH; i++) m_duty_s[i] = m_duty[i];
      if (dw) model_write(a, d);
      @(negedge clk);
    end
    cs = 1'b0; wren = 1'b0;
    bus_write(0, 32'(ctrl));
    @(negedge clk);
    check("off_out", 32'(out), 32'(inv));
    bus_write(3, 32'd1);
    m_wrap = 0;
    check("off_irq", 32'(irq), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int t;
    n_reset = 1'b0; cs = 1'b0; wren = 1'b0; adr = '0; di = '0;
    m_en = 0; m_center = 0; m_irq_en = 0; m_inv = 0; m_presc = 0; m_top = 255; m_wrap = 0;
    for (int i = 0; i < CH; i++) begin m_duty[i] = 0; m_duty_s[i] = 0; end
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_dout", dout, 32'd0);
    for (int a = 0; a <= 4 + CH; a++) begin
      bus_read(a, rd);
      check($sformatf("rst_rd%0d", a), rd, (a == 2) ? 32'hFF : 32'd0);
    end
    bus_read(31, rd);
    check("rst_rd31", rd, 32'd0);
    @(negedge clk);
    check("rst_dout_idle", dout, 32'd0);

    // Edge mode, mid-period duty change 3 -> 7 while the counter is 5.
    run_scenario(1, 9, 0, 0, 1, {8'd9, 8'd10, 8'd0, 8'd3}, 60, 1'b0, 1'b0, 10, 7, 20);
    check("edge_high_p0", 32'(hi0), 32'd6);
    check("edge_high_p1", 32'(hi1), 32'd14);

    // Centre mode with WRAP clears both on and off boundaries.
    run_scenario(0, 4, 1, 0, 1, {8'd4, 8'd5, 8'd0, 8'd2}, 40, 1'b0, 1'b1, -1, 0, 8);
    check("ctr_high_p0", 32'(hi0), 32'd3);
    check("ctr_high_p1", 32'(hi1), 32'd3);

    // Duty extremes with mixed polarity.
    run_scenario(2, 6, 0, 5, 0, {8'd7, 8'd0, 8'd7, 8'd0}, 50, 1'b0, 1'b0, -1, 0, 21);

    for (int s = 0; s < 8; s++) begin
      logic [CH-1:0][7:0] dv;
      t = $urandom_range(0, 12);
      for (int i = 0; i < CH; i++) dv[i] = 8'($urandom_range(0, t + 2));
      run_scenario($urandom_range(0, 3), t, $urandom_range(0, 1), $urandom_range(0, 15),
                   $urandom_range(0, 1), dv, 120, 1'b1, 1'b0, -1, 0, 1000);
    end

    // Reset in the middle of a running period.
    bus_write(1, 32'd0);
    bus_write(2, 32'd5);
    bus_write(4, 32'd3);
    bus_write(0, 32'h7D);
    repeat (8) @(negedge clk);
    check("pre_rst_irq", 32'(irq), 32'd1);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_dout", dout, 32'd0);
    bus_read(0, rd);
    check("mid_rst_ctrl", rd, 32'd0);
    bus_read(2, rd);
    check("mid_rst_top", rd, 32'hFF);
    bus_read(4, rd);
    check("mid_rst_duty0", rd, 32'd0);
    bus_read(3, rd);
    check("mid_rst_status", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
